// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator (800x600 @ 60 Hz defaults) with registered counters
// and strobes. Define VGA_TIMING_ASSERT_EN to compile in simulation-only range/strobe assertions.
module vga_timing #(
    parameter int unsigned HOR_PIXELS     = 800,
    parameter int unsigned HOR_TOTAL_TIME = 1056,
    parameter int unsigned HOR_SYNC_START = 840,
    parameter int unsigned HOR_SYNC_TIME  = 128,
    parameter int unsigned VER_PIXELS     = 600,
    parameter int unsigned VER_TOTAL_TIME = 628,
    parameter int unsigned VER_SYNC_START = 601,
    parameter int unsigned VER_SYNC_TIME  = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [10:0] vcount,
    output logic        vsync,
    output logic        vblnk
);

    localparam logic [10:0] HLast      = 11'(HOR_TOTAL_TIME - 1);
    localparam logic [10:0] VLast      = 11'(VER_TOTAL_TIME - 1);
    localparam logic [10:0] HPix       = 11'(HOR_PIXELS);
    localparam logic [10:0] VPix       = 11'(VER_PIXELS);
    localparam logic [10:0] HSyncStart = 11'(HOR_SYNC_START);
    localparam logic [10:0] HSyncEnd   = 11'(HOR_SYNC_START + HOR_SYNC_TIME);
    localparam logic [10:0] VSyncStart = 11'(VER_SYNC_START);
    localparam logic [10:0] VSyncEnd   = 11'(VER_SYNC_START + VER_SYNC_TIME);

    logic [10:0] hcount_d;
    logic [10:0] vcount_d;
    logic        hsync_d;
    logic        hblnk_d;
    logic        vsync_d;
    logic        vblnk_d;

    // Strobes are decoded from the next counter values so they land in the same cycle.
    always_comb begin
        hcount_d = hcount + 11'd1;
        vcount_d = vcount;
        if (hcount == HLast) begin
            hcount_d = '0;
            vcount_d = (vcount == VLast) ? '0 : vcount + 11'd1;
        end
        hblnk_d = (hcount_d >= HPix);
        hsync_d = (hcount_d >= HSyncStart) && (hcount_d < HSyncEnd);
        vblnk_d = (vcount_d >= VPix);
        vsync_d = (vcount_d >= VSyncStart) && (vcount_d < VSyncEnd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
            hsync  <= 1'b0;
            hblnk  <= 1'b0;
            vsync  <= 1'b0;
            vblnk  <= 1'b0;
        end else begin
            hcount <= hcount_d;
            vcount <= vcount_d;
            hsync  <= hsync_d;
            hblnk  <= hblnk_d;
            vsync  <= vsync_d;
            vblnk  <= vblnk_d;
        end
    end

`ifdef VGA_TIMING_ASSERT_EN
    hcount_range_a: assert property (@(posedge clk) disable iff (rst)
        32'(hcount) < HOR_TOTAL_TIME);
    vcount_range_a: assert property (@(posedge clk) disable iff (rst)
        32'(vcount) < VER_TOTAL_TIME);
    hsync_in_hblnk_a: assert property (@(posedge clk) disable iff (rst) hsync |-> hblnk);
    vsync_in_vblnk_a: assert property (@(posedge clk) disable iff (rst) vsync |-> vblnk);
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a default-size instance for reset and horizontal behaviour,
// and a shrunken instance (24x10 raster) so full frames and vertical strobes fit a short run.
module tb_vga_timing;

    logic        clk;
    logic        rst;
    logic [10:0] d_hcount, d_vcount, s_hcount, s_vcount;
    logic        d_hsync, d_hblnk, d_vsync, d_vblnk;
    logic        s_hsync, s_hblnk, s_vsync, s_vblnk;

    int unsigned n_total;
    int unsigned n_bad;

    vga_timing u_dut (
        .clk    (clk),
        .rst    (rst),
        .hcount (d_hcount),
        .hsync  (d_hsync),
        .hblnk  (d_hblnk),
        .vcount (d_vcount),
        .vsync  (d_vsync),
        .vblnk  (d_vblnk)
    );

    // Small raster: 16 visible of 24, hsync 18..20; 6 visible of 10 lines, vsync 7..8.
    vga_timing #(
        .HOR_PIXELS     (16),
        .HOR_TOTAL_TIME (24),
        .HOR_SYNC_START (18),
        .HOR_SYNC_TIME  (3),
        .VER_PIXELS     (6),
        .VER_TOTAL_TIME (10),
        .VER_SYNC_START (7),
        .VER_SYNC_TIME  (2)
    ) u_small (
        .clk    (clk),
        .rst    (rst),
        .hcount (s_hcount),
        .hsync  (s_hsync),
        .hblnk  (s_hblnk),
        .vcount (s_vcount),
        .vsync  (s_vsync),
        .vblnk  (s_vblnk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d"}, {d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk}, 32'd0);
        check({tag, "_s"}, {s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk}, 32'd0);
    endtask

    initial begin
        int n;
        int bound_err, hs_cnt, hs_first, hs_last, hb_rise, hb_fall;
        logic prev;
        n_total = 0;
        n_bad   = 0;

        // Power-on reset held for two edges.
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("por");
        rst = 1'b0;
        tick();
        check("por_release_hcount", 32'(d_hcount), 32'd1);
        check("por_release_vcount", 32'(d_vcount), 32'd0);

        // Run into the hsync window, then reset mid-line.
        n = 0;
        while (d_hcount != 11'd900 && n < 2000) begin tick(); n++; end
        check("reach_h900", 32'(d_hcount), 32'd900);
        check("h900_strobes", {30'd0, d_hsync, d_hblnk}, 32'd3);
        #3 rst = 1'b1;
        #1 check_all_zero("async_clear");
        tick();
        tick();
        check_all_zero("reset_hold");
        rst = 1'b0;
        tick();
        check("midline_release_hcount", 32'(d_hcount), 32'd1);

        // One full line of horizontal strobes, starting from hcount 0 of line 1.
        n = 0;
        while (d_hcount != 11'd0 && n < 2000) begin tick(); n++; end
        check("line1_start_vcount", 32'(d_vcount), 32'd1);
        hs_cnt = 0; hs_first = -1; hs_last = -1; hb_rise = -1; hb_fall = -1;
        bound_err = 0;
        prev = d_hblnk;
        for (int i = 0; i <= 1056; i++) begin
            if (d_hblnk && !prev && hb_rise < 0) hb_rise = int'(d_hcount);
            if (!d_hblnk && prev && hb_fall < 0) hb_fall = int'(d_hcount);
            if (i < 1056 && d_hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_hcount);
                hs_last = int'(d_hcount);
            end
            if (d_hcount > 11'd1055 || d_vcount > 11'd627) bound_err++;
            prev = d_hblnk;
            if (i < 1056) tick();
        end
        check("hblnk_rise_at", 32'(hb_rise), 32'd800);
        check("hblnk_fall_at", 32'(hb_fall), 32'd0);
        check("hsync_width", 32'(hs_cnt), 32'd128);
        check("hsync_first", 32'(hs_first), 32'd840);
        check("hsync_last", 32'(hs_last), 32'd967);

        // Line wrap at vcount 5.
        n = 0;
        while (!(d_hcount == 11'd1055 && d_vcount == 11'd5) && n < 7000) begin
            if (d_hcount > 11'd1055 || d_vcount > 11'd627) bound_err++;
            tick();
            n++;
        end
        check("reach_line5_end", {d_vcount, d_hcount}, {11'd5, 11'd1055});
        tick();
        check("line_wrap_hcount", 32'(d_hcount), 32'd0);
        check("line_wrap_vcount", 32'(d_vcount), 32'd6);
        check("default_bounds", 32'(bound_err), 32'd0);

        // Small raster: align to frame start, then scan two whole frames.
        n = 0;
        while (!(s_hcount == 11'd0 && s_vcount == 11'd0) && n < 300) begin tick(); n++; end
        check("small_frame_start", {s_vcount, s_hcount}, 32'd0);
        begin
            int   step_err, strobe_err, edge_h_err, wraps, vs_cnt, vs_first, vs_last;
            int   vb_rise, vb_fall, fall0, fall1;
            logic [10:0] ph, pv;
            logic pvs, pvb;
            step_err = 0; strobe_err = 0; edge_h_err = 0; wraps = 0; vs_cnt = 0;
            vs_first = -1; vs_last = -1; vb_rise = -1; vb_fall = -1; fall0 = -1; fall1 = -1;
            bound_err = 0;
            ph = s_hcount; pv = s_vcount; pvs = s_vsync; pvb = s_vblnk;
            for (int i = 0; i <= 480; i++) begin
                if (i > 0) begin
                    if (ph == 11'd23) begin
                        if (s_hcount != 11'd0) step_err++;
                        if (pv == 11'd9) begin
                            if (s_vcount == 11'd0) wraps++; else step_err++;
                        end else if (s_vcount != pv + 11'd1) step_err++;
                    end else if (s_hcount != ph + 11'd1 || s_vcount != pv) step_err++;
                    if (s_vsync != pvs && s_hcount != 11'd0) edge_h_err++;
                    if (!s_vsync && pvs) begin
                        if (fall0 < 0) fall0 = i; else if (fall1 < 0) fall1 = i;
                    end
                    if (s_vblnk && !pvb && vb_rise < 0) vb_rise = int'(s_vcount);
                    if (!s_vblnk && pvb && vb_fall < 0) vb_fall = int'(s_vcount);
                end
                if (s_hcount > 11'd23 || s_vcount > 11'd9) bound_err++;
                if (s_hblnk != (s_hcount >= 11'd16)) strobe_err++;
                if (s_hsync != (s_hcount >= 11'd18 && s_hcount <= 11'd20)) strobe_err++;
                if (s_vblnk != (s_vcount >= 11'd6)) strobe_err++;
                if (s_vsync) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = int'(s_vcount);
                    vs_last = int'(s_vcount);
                end
                ph = s_hcount; pv = s_vcount; pvs = s_vsync; pvb = s_vblnk;
                if (i < 480) tick();
            end
            check("small_step", 32'(step_err), 32'd0);
            check("small_frame_wraps", 32'(wraps), 32'd2);
            check("small_bounds", 32'(bound_err), 32'd0);
            check("small_strobes", 32'(strobe_err), 32'd0);
            check("vsync_edge_hcount", 32'(edge_h_err), 32'd0);
            check("vsync_clocks", 32'(vs_cnt), 32'd96);
            check("vsync_first_line", 32'(vs_first), 32'd7);
            check("vsync_last_line", 32'(vs_last), 32'd8);
            check("vblnk_rise_line", 32'(vb_rise), 32'd6);
            check("vblnk_fall_line", 32'(vb_fall), 32'd0);
            check("vsync_fall_period", 32'(fall1 - fall0), 32'd240);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
